// File: rtl/fanin_rr_merge.sv
// fanin_rr_merge: N-to-1 valid/ready merge with round-robin arbitration
// over enabled, valid inputs and a one-entry registered output stage.
// Optional per-input burst grants are compiled in with FANIN_BURST_EN.
module fanin_rr_merge #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 17,
  parameter int SRC_W     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  input  logic [NUM_IN-1:0]        E,
  input  logic [NUM_IN-1:0]        I_valid,
  input  logic [NUM_IN*DATA_W-1:0] I_data,
  output logic [NUM_IN-1:0]        I_ready,
  output logic                     O_valid,
  output logic [DATA_W-1:0]        O_data,
  output logic [SRC_W-1:0]         O_src,
  input  logic                     O_ready
);

  logic [NUM_IN-1:0] w_elig;
  logic              w_any;
  logic [SRC_W-1:0]  w_rr_idx;
  logic [SRC_W-1:0]  w_gnt_idx;
  logic [SRC_W-1:0]  w_next_ptr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_accept;
  logic              w_ptr_adv;

  logic [SRC_W-1:0]  r_ptr;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SRC_W-1:0]  r_src;

  assign w_elig = E & I_valid;

  // Round-robin search: first eligible index starting at r_ptr, wrapping
  always_comb begin
    int unsigned v_idx;
    v_idx    = 0;
    w_any    = 1'b0;
    w_rr_idx = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      v_idx = (int'(r_ptr) + k) % NUM_IN;
      if (!w_any && w_elig[v_idx[SRC_W-1:0]]) begin
        w_any    = 1'b1;
        w_rr_idx = v_idx[SRC_W-1:0];
      end
    end
  end

`ifdef FANIN_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_hold;
  logic             w_burst_sel;

  // The last granted input is the one recorded in r_src.
  assign w_burst_sel = r_hold && w_elig[r_src] && (r_cnt < CNT_W'(MAX_BURST));
  assign w_gnt_idx   = w_burst_sel ? r_src : w_rr_idx;
  // Burst continuations keep ptr parked at (g+1) so round-robin resumes there.
  assign w_ptr_adv   = w_accept && !w_burst_sel;

  // Burst counter and held-grant flag
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_cnt  <= '0;
      r_hold <= 1'b0;
    end else if (w_accept) begin
      if (w_burst_sel) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt  <= CNT_W'(1);
        r_hold <= 1'b1;
      end
    end else if (!w_elig[r_src]) begin
      r_cnt  <= '0;
      r_hold <= 1'b0;
    end
  end
`else
  assign w_gnt_idx = w_rr_idx;
  assign w_ptr_adv = w_accept;
`endif

  assign w_accept   = (!r_valid || O_ready) && w_any;
  assign w_gnt_data = I_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_next_ptr = (w_gnt_idx == SRC_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + 1'b1;

  // One-hot ready to the granted input, forced low during reset
  always_comb begin
    I_ready = '0;
    if (w_accept && !ASYNCRESET) begin
      I_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Round-robin pointer
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_ptr <= w_next_ptr;
    end
  end

  // Output register: load on accept, clear valid on drain, hold on stall
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_src   <= w_gnt_idx;
    end else if (O_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign O_valid = r_valid;
  assign O_data  = r_data;
  assign O_src   = r_src;

endmodule

// File: tb/tb_fanin_rr_merge.sv
// Directed testbench for fanin_rr_merge (NUM_IN=4, DATA_W=17).
// Burst expectations follow FANIN_BURST_EN when the bench is built with it.
module tb_fanin_rr_merge;

  localparam int NUM_IN = 4;
  localparam int DATA_W = 17;
  localparam int SRC_W  = 2;

  logic                     CLK;
  logic                     ASYNCRESET;
  logic [NUM_IN-1:0]        E;
  logic [NUM_IN-1:0]        I_valid;
  logic [NUM_IN*DATA_W-1:0] I_data;
  logic [NUM_IN-1:0]        I_ready;
  logic                     O_valid;
  logic [DATA_W-1:0]        O_data;
  logic [SRC_W-1:0]         O_src;
  logic                     O_ready;

  int n_pass;
  int n_total;

  logic [DATA_W-1:0] pay [NUM_IN];

  fanin_rr_merge #(
    .NUM_IN   (NUM_IN),
    .DATA_W   (DATA_W),
    .SRC_W    (SRC_W),
    .MAX_BURST(4)
  ) dut (
    .CLK       (CLK),
    .ASYNCRESET(ASYNCRESET),
    .E         (E),
    .I_valid   (I_valid),
    .I_data    (I_data),
    .I_ready   (I_ready),
    .O_valid   (O_valid),
    .O_data    (O_data),
    .O_src     (O_src),
    .O_ready   (O_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_payloads();
    for (int i = 0; i < NUM_IN; i++) I_data[i*DATA_W +: DATA_W] = pay[i];
  endtask

  task automatic do_reset();
    ASYNCRESET = 1'b1;
    E = '0; I_valid = '0; O_ready = 1'b0;
    pay[0] = 17'h000A0; pay[1] = 17'h000B1; pay[2] = 17'h000C2; pay[3] = 17'h000D3;
    load_payloads();
    tick();
    tick();
    ASYNCRESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    ASYNCRESET = 1'b1;
    E = 4'b1111; I_valid = 4'b1111; O_ready = 1'b1;
    tick();
    n_total++;
    if (O_valid !== 1'b0 || O_data !== 17'h0 || O_src !== 2'd0) $display("FAIL reset_out: valid=%b data=%h src=%0d, need 0/0/0", O_valid, O_data, O_src);
    else n_pass++;
    n_total++;
    if (I_ready !== 4'b0000) $display("FAIL reset_iready: got %b need 0000", I_ready);
    else n_pass++;
    ASYNCRESET = 1'b0;
    #1;
    n_total++;
    if (I_ready !== 4'b0001) $display("FAIL reset_first_grant: I_ready=%b need 0001", I_ready);
    else n_pass++;
    tick();
    n_total++;
    if (O_valid !== 1'b1 || O_src !== 2'd0 || O_data !== pay[0]) $display("FAIL reset_first_beat: valid=%b src=%0d data=%h need 1/0/%h", O_valid, O_src, O_data, pay[0]);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    pay[0] = 17'h001AB; load_payloads();
    E = 4'b1111; I_valid = 4'b0001; O_ready = 1'b0;
    tick();
    n_total++;
    if (O_valid !== 1'b1 || O_data !== 17'h001AB) $display("FAIL mid_load: valid=%b data=%h need 1/1ab", O_valid, O_data);
    else n_pass++;
    #2;
    ASYNCRESET = 1'b1;
    #1;
    n_total++;
    if (O_valid !== 1'b0 || O_data !== 17'h0 || O_src !== 2'd0 || I_ready !== 4'b0000)
      $display("FAIL mid_reset: valid=%b data=%h src=%0d rdy=%b need 0/0/0/0000", O_valid, O_data, O_src, I_ready);
    else n_pass++;
    #1;
    ASYNCRESET = 1'b0;
    I_valid = 4'b1111; O_ready = 1'b1;
    tick();
    n_total++;
    if (O_valid !== 1'b1 || O_src !== 2'd0) $display("FAIL mid_after: valid=%b src=%0d need 1/0", O_valid, O_src);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [SRC_W-1:0] exp_src [5];
    logic [NUM_IN-1:0] exp_rdy;
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    E = 4'b1111; I_valid = 4'b1111; O_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (O_valid !== 1'b1 || O_src !== exp_src[k] || O_data !== pay[exp_src[k]])
        $display("FAIL rr_beat%0d: valid=%b src=%0d data=%h need 1/%0d/%h", k, O_valid, O_src, O_data, exp_src[k], pay[exp_src[k]]);
      else n_pass++;
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      n_total++;
      if (I_ready !== exp_rdy) $display("FAIL rr_ready%0d: got %b need %b", k, I_ready, exp_rdy);
      else n_pass++;
    end
  endtask

  task automatic test_enable_mask();
    logic [SRC_W-1:0] exp_src [4];
    exp_src = '{2'd0, 2'd2, 2'd0, 2'd2};
    do_reset();
    E = 4'b0101; I_valid = 4'b1111; O_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++;
      if ((I_ready & 4'b1010) !== 4'b0000) $display("FAIL mask_ready%0d: I_ready=%b disabled bits set", k, I_ready);
      else n_pass++;
      tick();
      n_total++;
      if (O_valid !== 1'b1 || O_src !== exp_src[k]) $display("FAIL mask_src%0d: valid=%b src=%0d need 1/%0d", k, O_valid, O_src, exp_src[k]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    pay[2] = 17'h00055; load_payloads();
    E = 4'b1111; I_valid = 4'b0100; O_ready = 1'b0;
    tick();
    I_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if (I_ready !== 4'b0000) $display("FAIL stall_ready%0d: got %b need 0000", k, I_ready);
      else n_pass++;
      tick();
      n_total++;
      if (O_valid !== 1'b1 || O_src !== 2'd2 || O_data !== 17'h00055)
        $display("FAIL stall_hold%0d: valid=%b src=%0d data=%h need 1/2/55", k, O_valid, O_src, O_data);
      else n_pass++;
    end
    O_ready = 1'b1;
    #1;
    n_total++;
    if (I_ready !== 4'b1000) $display("FAIL stall_release_ready: got %b need 1000", I_ready);
    else n_pass++;
    tick();
    n_total++;
    if (O_valid !== 1'b1 || O_src !== 2'd3 || O_data !== pay[3])
      $display("FAIL stall_swap: valid=%b src=%0d data=%h need 1/3/%h", O_valid, O_src, O_data, pay[3]);
    else n_pass++;
    I_valid = 4'b0000;
    tick();
    n_total++;
    if (O_valid !== 1'b0 || O_src !== 2'd3 || O_data !== pay[3])
      $display("FAIL drain_hold: valid=%b src=%0d data=%h need 0/3/%h", O_valid, O_src, O_data, pay[3]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    E = 4'b1111; O_ready = 1'b1;
    I_valid = 4'b0100;
    tick();
    I_valid = 4'b1000;
    tick();
    n_total++;
    if (O_src !== 2'd3) $display("FAIL wrap_g3: src=%0d need 3", O_src);
    else n_pass++;
    I_valid = 4'b0010;
    tick();
    n_total++;
    if (O_valid !== 1'b1 || O_src !== 2'd1 || O_data !== pay[1]) $display("FAIL wrap_g1: valid=%b src=%0d need 1/1", O_valid, O_src);
    else n_pass++;
    I_valid = 4'b1011;
    tick();
    n_total++;
    if (O_src !== 2'd3) $display("FAIL wrap_from2: src=%0d need 3", O_src);
    else n_pass++;
    I_valid = 4'b0011;
    tick();
    n_total++;
    if (O_src !== 2'd0) $display("FAIL wrap_to0: src=%0d need 0", O_src);
    else n_pass++;
  endtask

  task automatic test_all_disabled();
    do_reset();
    E = 4'b1111; I_valid = 4'b0010; O_ready = 1'b0;
    tick();
    E = 4'b0000; I_valid = 4'b1111; O_ready = 1'b1;
    #1;
    n_total++;
    if (I_ready !== 4'b0000) $display("FAIL dis_ready: got %b need 0000", I_ready);
    else n_pass++;
    tick();
    n_total++;
    if (O_valid !== 1'b0 || O_src !== 2'd1) $display("FAIL dis_drain: valid=%b src=%0d need 0/1", O_valid, O_src);
    else n_pass++;
    tick();
    n_total++;
    if (O_valid !== 1'b0) $display("FAIL dis_idle: valid=%b need 0", O_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [SRC_W-1:0] exp_src [9];
`ifdef FANIN_BURST_EN
    exp_src = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
`else
    exp_src = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif
    do_reset();
    E = 4'b1111; I_valid = 4'b0011; O_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_total++;
      if (O_valid !== 1'b1 || O_src !== exp_src[k]) $display("FAIL b2b_beat%0d: valid=%b src=%0d need 1/%0d", k, O_valid, O_src, exp_src[k]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    ASYNCRESET = 1'b1;
    E = '0; I_valid = '0; O_ready = 1'b0; I_data = '0;
    test_reset();
    test_reset_midstream();
    test_round_robin();
    test_enable_mask();
    test_stall();
    test_wrap();
    test_all_disabled();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
